alu_share_ctrl: RTL



---
 rtl/alu_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/alu_share_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the shared-ALU sequencer: widths, opcodes, FSM encoding
// and the opcode legality check.
package alu_pkg;

  localparam int W     = 32;
  localparam int CTR_W = 4;

  localparam logic [CTR_W-1:0] ADD = 4'd0;
  localparam logic [CTR_W-1:0] SUB = 4'd1;
  localparam logic [CTR_W-1:0] OR  = 4'd2;
  localparam logic [CTR_W-1:0] AND = 4'd3;
  localparam logic [CTR_W-1:0] SLT = 4'd4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  function automatic logic is_legal(input logic [CTR_W-1:0] ctr);
    return ctr <= SLT;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Priority moves to the port that was not just
// served, and only when the served operation completes (done strobe).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    prio_d = prio_q;
    if (done) begin
      prio_d = ~done_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign gnt_valid = |req;
  assign gnt_id    = (req == 2'b11) ? prio_q : req[1];

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one single-cycle ALU between two requesters: grant in IDLE,
// drive registered operands in EXEC, hold the owner's response in RESP.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W     = alu_pkg::W,
  parameter int CTR_W = alu_pkg::CTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [W-1:0]     r0_a,
  input  logic [W-1:0]     r0_b,
  input  logic [CTR_W-1:0] r0_ctr,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [W-1:0]     r0_rsp_data,
  output logic             r0_rsp_over,
  output logic             r0_rsp_ill,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [W-1:0]     r1_a,
  input  logic [W-1:0]     r1_b,
  input  logic [CTR_W-1:0] r1_ctr,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [W-1:0]     r1_rsp_data,
  output logic             r1_rsp_over,
  output logic             r1_rsp_ill,
  output logic [W-1:0]     busA,
  output logic [W-1:0]     busB,
  output logic [CTR_W-1:0] ALUctr,
  input  logic [W-1:0]     Alu_out,
  input  logic             over
);

  // Handshake: a request transfers when valid and ready are both high at a
  // rising edge; a response transfers when rsp_valid and rsp_ready are both high.
  logic [1:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [1:0]          rsp_over_q, rsp_over_d;
  logic [1:0]          rsp_ill_q, rsp_ill_d;
  logic [1:0][W-1:0]   rsp_data_q, rsp_data_d;

  logic [1:0] req;
  logic [1:0] rsp_ready;
  logic       gnt_valid;
  logic       gnt_id;
  logic       accept;
  logic       done;

  assign req       = {r1_valid, r0_valid};
  assign rsp_ready = {r1_rsp_ready, r0_rsp_ready};
  assign accept    = (state_q == IDLE) && gnt_valid;
  assign done      = (state_q == RESP) && rsp_valid_q[owner_q] && rsp_ready[owner_q];

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .done_id   (owner_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    ctr_d       = ctr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_over_d  = rsp_over_q;
    rsp_ill_d   = rsp_ill_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt_id;
          a_d     = gnt_id ? r1_a   : r0_a;
          b_d     = gnt_id ? r1_b   : r0_b;
          ctr_d   = gnt_id ? r1_ctr : r0_ctr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d[owner_q] = 1'b1;
        // Illegal opcodes never expose whatever the ALU happens to output.
        if (is_legal(ctr_q)) begin
          rsp_data_d[owner_q] = Alu_out;
          rsp_over_d[owner_q] = (ctr_q == ADD) && over;
          rsp_ill_d[owner_q]  = 1'b0;
        end else begin
          rsp_data_d[owner_q] = '0;
          rsp_over_d[owner_q] = 1'b0;
          rsp_ill_d[owner_q]  = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (done) begin
          rsp_valid_d[owner_q] = 1'b0;
          state_d              = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_over_q  <= '0;
      rsp_ill_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctr_q       <= ctr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_over_q  <= rsp_over_d;
      rsp_ill_q   <= rsp_ill_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign r0_ready     = accept && !gnt_id;
  assign r1_ready     = accept && gnt_id;
  assign busA         = a_q;
  assign busB         = b_q;
  assign ALUctr       = ctr_q;
  assign r0_rsp_valid = rsp_valid_q[0];
  assign r1_rsp_valid = rsp_valid_q[1];
  assign r0_rsp_data  = rsp_data_q[0];
  assign r1_rsp_data  = rsp_data_q[1];
  assign r0_rsp_over  = rsp_over_q[0];
  assign r1_rsp_over  = rsp_over_q[1];
  assign r0_rsp_ill   = rsp_ill_q[0];
  assign r1_rsp_ill   = rsp_ill_q[1];

endmodule
